// File: rtl/pulse_delay_sched_if.sv
// Bundle of data/config signals for pulse_delay_sched.
// Optional macro: PULSE_DELAY_SCHED_WIDTH_EN adds cfg_width.
//
// Handshake: there is no ready signal. cfg_we is a single-cycle write strobe
// that is taken only while busy==0; a write seen while busy==1 is dropped and
// answered with a one-cycle cfg_rej pulse on the following cycle. pulse_in is
// an event line (rising edge = one event); pulse_out carries the delayed event.
interface pulse_delay_sched_if #(
  parameter int CNT_W = 16,
  parameter int DEPTH = 8
);
  localparam int PC_W = $clog2(DEPTH) + 1;

  logic             pulse_in;
  logic             cfg_we;
  logic [CNT_W-1:0] cfg_delay;
  logic             cfg_rej;
  logic [CNT_W-1:0] cur_delay;
  logic             pulse_out;
  logic             busy;
  logic [PC_W-1:0]  pend_cnt;
  logic             ovf_sticky;
  logic             ovf_clr;
`ifdef PULSE_DELAY_SCHED_WIDTH_EN
  logic [7:0]       cfg_width;

  modport master (
    output pulse_in, cfg_we, cfg_delay, ovf_clr, cfg_width,
    input  cfg_rej, cur_delay, pulse_out, busy, pend_cnt, ovf_sticky
  );
  modport slave (
    input  pulse_in, cfg_we, cfg_delay, ovf_clr, cfg_width,
    output cfg_rej, cur_delay, pulse_out, busy, pend_cnt, ovf_sticky
  );
`else
  modport master (
    output pulse_in, cfg_we, cfg_delay, ovf_clr,
    input  cfg_rej, cur_delay, pulse_out, busy, pend_cnt, ovf_sticky
  );
  modport slave (
    input  pulse_in, cfg_we, cfg_delay, ovf_clr,
    output cfg_rej, cur_delay, pulse_out, busy, pend_cnt, ovf_sticky
  );
`endif
endinterface

// File: rtl/pulse_delay_sched.sv
// Programmable pulse-delay scheduler on alg_clk.
// Each rising edge of pulse_in is timestamped with a free-running counter and
// re-emitted exactly cur_delay cycles later. Up to DEPTH events in flight.
// Optional macro: PULSE_DELAY_SCHED_WIDTH_EN stretches each output pulse to
// max(cfg_width,1) cycles; without it every event gives a 1-cycle pulse.
//
// pend_cnt counts events that have been accepted and whose pulse_out cycle has
// not yet passed: an entry leaves the due-time FIFO one cycle before its pulse
// appears, and the counter drops the cycle after the pulse. So FIFO occupancy
// is pend_cnt minus the entry currently being emitted.
module pulse_delay_sched #(
  parameter int CNT_W     = 16,
  parameter int DEPTH     = 8,
  parameter int DEF_DELAY = 21
) (
  input  logic                alg_clk,
  input  logic                alg_rst_n,
  pulse_delay_sched_if.slave  bus,
  output logic                o_dbg_state
);
  localparam int              PTR_W = $clog2(DEPTH);
  localparam int              PC_W  = PTR_W + 1;
  localparam logic [PC_W-1:0] FULL  = PC_W'(DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_ARMED = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_ts;
  logic [CNT_W-1:0] r_cur_delay;
  logic             r_prev;
  logic             r_emit;
  logic             r_rej;
  logic             r_ovf;
  logic [PC_W-1:0]  r_pend, w_pend_nxt;
  logic [PTR_W:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_due [DEPTH];

  logic             w_edge, w_fifo_empty, w_pop, w_push, w_drop, w_cfg_ok;
  logic [CNT_W-1:0] w_cfg_clamped, w_due_new;

  assign w_edge        = bus.pulse_in & ~r_prev;
  assign w_fifo_empty  = (r_wr_ptr == r_rd_ptr);
  // Head is always the earliest due time, so an equality match is enough.
  assign w_pop         = ~w_fifo_empty && (r_due[r_rd_ptr[PTR_W-1:0]] == r_ts);
  // A full queue still takes an event in the cycle the oldest one is emitted.
  assign w_push        = w_edge && ((r_pend != FULL) || r_emit);
  assign w_drop        = w_edge && (r_pend == FULL) && ~r_emit;
  assign w_cfg_ok      = bus.cfg_we && (r_state == S_IDLE);
  assign w_cfg_clamped = (bus.cfg_delay < CNT_W'(2)) ? CNT_W'(2) : bus.cfg_delay;
  // Pop happens at due, pulse one cycle later: total latency = cur_delay.
  assign w_due_new     = r_ts + r_cur_delay - CNT_W'(1);

  // Pending-count update and IDLE/ARMED next state.
  always_comb begin
    w_pend_nxt  = r_pend;
    w_state_nxt = r_state;
    if (w_push && !r_emit) begin
      w_pend_nxt = r_pend + PC_W'(1);
    end else if (!w_push && r_emit) begin
      w_pend_nxt = r_pend - PC_W'(1);
    end
    case (r_state)
      S_IDLE:  if (w_pend_nxt != '0) w_state_nxt = S_ARMED;
      S_ARMED: if (w_pend_nxt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control registers, timestamp counter and FIFO pointers.
  always_ff @(posedge alg_clk) begin
    if (!alg_rst_n) begin
      r_state     <= S_IDLE;
      r_pend      <= '0;
      r_ts        <= '0;
      r_prev      <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_emit      <= 1'b0;
      r_rej       <= 1'b0;
      r_ovf       <= 1'b0;
      r_cur_delay <= CNT_W'(DEF_DELAY);
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_ts    <= r_ts + CNT_W'(1);
      r_prev  <= bus.pulse_in;
      r_emit  <= w_pop;
      r_rej   <= bus.cfg_we && (r_state == S_ARMED);
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_ovf <= 1'b0;
      end
      if (w_cfg_ok) r_cur_delay <= w_cfg_clamped;
      if (w_push)   r_wr_ptr    <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_pop)    r_rd_ptr    <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Due-time storage; contents are don't-care once the pointers reset.
  always_ff @(posedge alg_clk) begin
    if (w_push) r_due[r_wr_ptr[PTR_W-1:0]] <= w_due_new;
  end

`ifdef PULSE_DELAY_SCHED_WIDTH_EN
  logic [7:0] r_width;
  logic [7:0] r_wcnt;

  // Pulse stretcher: a pop (re)loads the width counter so pulses merge.
  always_ff @(posedge alg_clk) begin
    if (!alg_rst_n) begin
      r_width <= 8'd1;
      r_wcnt  <= 8'd0;
    end else begin
      if (w_cfg_ok) r_width <= bus.cfg_width;
      if (w_pop) begin
        r_wcnt <= (r_width == 8'd0) ? 8'd1 : r_width;
      end else if (r_wcnt != 8'd0) begin
        r_wcnt <= r_wcnt - 8'd1;
      end
    end
  end

  assign bus.pulse_out = (r_wcnt != 8'd0);
`else
  assign bus.pulse_out = r_emit;
`endif

  assign bus.cfg_rej    = r_rej;
  assign bus.cur_delay  = r_cur_delay;
  assign bus.busy       = (r_state == S_ARMED);
  assign bus.pend_cnt   = r_pend;
  assign bus.ovf_sticky = r_ovf;
  assign o_dbg_state    = (r_state == S_ARMED);
endmodule
